// File: rtl/intr_sequencer_if.sv
// ----------------------------------------------------------------------------
// intr_sequencer_if
//   Bus bundle between the interrupt sequencer and the blocks it drives:
//   stack-push handshake, vector-read handshake and the PC overwrite strobe.
//
//   Handshake rule for both push and vector channels: the sequencer raises
//   its req and holds req plus payload (push_data / vec_addr) constant until
//   the responder answers with a one-cycle ack. The transfer completes on the
//   clock edge that samples req=1 and ack=1 together. An ack seen while req
//   is low is meaningless and is dropped by the sequencer.
//
//   master : the sequencer (drives req/payload/pc_load, samples acks)
//   slave  : stack/memory/PC side (drives acks and vec_data)
// ----------------------------------------------------------------------------
interface intr_sequencer_if #(
  parameter int AW = 8
);
  logic          push_req;
  logic [AW-1:0] push_data;
  logic          push_ack;
  logic          vec_req;
  logic [AW-1:0] vec_addr;
  logic          vec_ack;
  logic [AW-1:0] vec_data;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;

  modport master (
    output push_req, push_data, vec_req, vec_addr, pc_load, pc_load_val,
    input  push_ack, vec_ack, vec_data
  );

  modport slave (
    input  push_req, push_data, vec_req, vec_addr, pc_load, pc_load_val,
    output push_ack, vec_ack, vec_data
  );
endinterface

// File: rtl/intr_sequencer.sv
// ----------------------------------------------------------------------------
// intr_sequencer
//   Sequences ISR entry and exit for the pipelined 8-bit CPU: on a pending
//   interrupt it freezes fetch, drains the pipeline, pushes the return PC,
//   reads the ISR vector, redirects the PC, clears the flag and wakes the
//   core from HLT. Nesting is blocked until RTI retires.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   intr_flag       pending interrupt (owned by the ports/interrupt block)
//   intr_clear      one-cycle pulse clearing intr_flag
//   hlt / wake      core halted / one-cycle release pulse
//   pipe_busy       instruction still in EX/MEM/WB
//   pc_in           address of next unfetched instruction
//   stall_fetch     freeze PC/IF
//   flush_if        kill IF/ID contents
//   bus             push / vector handshakes and PC load (master modport)
//   rti             RTI retired this cycle
//   in_service      ISR active
//   dbg_state       current FSM state encoding
// ----------------------------------------------------------------------------
module intr_sequencer #(
  parameter int          AW           = 8,
  parameter logic [AW-1:0] VECTOR_ADDR = 'h01,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 intr_flag,
  output logic                 intr_clear,
  input  logic                 hlt,
  output logic                 wake,
  input  logic                 pipe_busy,
  input  logic [AW-1:0]        pc_in,
  output logic                 stall_fetch,
  output logic                 flush_if,
  intr_sequencer_if.master     bus,
  input  logic                 rti,
  output logic                 in_service,
  output logic [2:0]           dbg_state
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    PUSH    = 3'd2,
    VEC     = 3'd3,
    LOAD    = 3'd4,
    SERVICE = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;   // marks the first DRAIN cycle for flush_if
  logic [AW-1:0] ret_pc_q, ret_pc_d;
  logic [AW-1:0] vector_q, vector_d;

  logic          push_req;
  logic [AW-1:0] push_data;
  logic          vec_req;
  logic [AW-1:0] vec_addr;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      ret_pc_q <= '0;
      vector_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      ret_pc_q <= ret_pc_d;
      vector_q <= vector_d;
    end
  end

  // Next-state logic. Acks are only looked at in their own state, so stray
  // acks elsewhere fall through the default "hold" assignments.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = 1'b0;
    ret_pc_d = ret_pc_q;
    vector_d = vector_q;
    case (state_q)
      IDLE: begin
        // in_service is always 0 here, so the flag alone starts entry.
        if (intr_flag) begin
          state_d = DRAIN;
          cnt_d   = CNT_INIT;
          first_d = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        // Fetch is frozen, so pc_in is the next unfetched instruction.
        if (cnt_q == '0 && !pipe_busy) begin
          ret_pc_d = pc_in;
          state_d  = PUSH;
        end
      end
      PUSH: begin
        if (bus.push_ack) state_d = VEC;
      end
      VEC: begin
        if (bus.vec_ack) begin
          vector_d = bus.vec_data;
          state_d  = LOAD;
        end
      end
      LOAD: state_d = SERVICE;
      SERVICE: begin
        // intr_flag is deliberately not looked at here: no nesting.
        if (rti) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state register only; payloads come from registers,
  // so no ack can reach a req combinationally.
  always_comb begin
    stall_fetch = 1'b0;
    flush_if    = 1'b0;
    push_req    = 1'b0;
    push_data   = '0;
    vec_req     = 1'b0;
    vec_addr    = '0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    intr_clear  = 1'b0;
    wake        = 1'b0;
    in_service  = 1'b0;
    case (state_q)
      DRAIN: begin
        stall_fetch = 1'b1;
        flush_if    = first_q;
      end
      PUSH: begin
        stall_fetch = 1'b1;
        push_req    = 1'b1;
        push_data   = ret_pc_q;
      end
      VEC: begin
        stall_fetch = 1'b1;
        vec_req     = 1'b1;
        vec_addr    = VECTOR_ADDR;
      end
      LOAD: begin
        stall_fetch = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = vector_q;
        intr_clear  = 1'b1;
        wake        = hlt;   // coincides with pc_load so the core resumes at the ISR
      end
      SERVICE: in_service = 1'b1;
      default: ;
    endcase
  end

  assign bus.push_req    = push_req;
  assign bus.push_data   = push_data;
  assign bus.vec_req     = vec_req;
  assign bus.vec_addr    = vec_addr;
  assign bus.pc_load     = pc_load;
  assign bus.pc_load_val = pc_load_val;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_intr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_intr_sequencer
//   Bench for intr_sequencer. Expected timing of each ISR entry is derived
//   arithmetically from the drain length, pipe_busy extension and ack waits.
// ----------------------------------------------------------------------------
module tb_intr_sequencer;
  localparam int AW = 8;
  localparam int D  = 3;
  localparam logic [AW-1:0] VADDR = 8'h01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          intr_flag, hlt, pipe_busy, rti;
  logic [AW-1:0] pc_in;
  logic          intr_clear, wake, stall_fetch, flush_if, in_service;
  logic [2:0]    dbg_state;

  intr_sequencer_if #(.AW(AW)) bus ();

  intr_sequencer #(.AW(AW), .VECTOR_ADDR(VADDR), .DRAIN_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .intr_flag   (intr_flag),
    .intr_clear  (intr_clear),
    .hlt         (hlt),
    .wake        (wake),
    .pipe_busy   (pipe_busy),
    .pc_in       (pc_in),
    .stall_fetch (stall_fetch),
    .flush_if    (flush_if),
    .bus         (bus.master),
    .rti         (rti),
    .in_service  (in_service),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {stall, flush, push_req, vec_req, pc_load, intr_clear, wake, in_service}
  function automatic logic [7:0] outs();
    return {stall_fetch, flush_if, bus.push_req, bus.vec_req,
            bus.pc_load, intr_clear, wake, in_service};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    intr_flag = 1'b0; hlt = 1'b0; pipe_busy = 1'b0; rti = 1'b0;
    pc_in = '0; bus.push_ack = 1'b0; bus.vec_ack = 1'b0; bus.vec_data = '0;
  endtask

  // ---------------- driver + reference model ----------------
  // Cycle 0 is the IDLE cycle with intr_flag=1. Drain lasts D+b cycles,
  // push lasts w1+1, vector read w2+1, then LOAD at cycle l = D+3+b+w1+w2.
  task automatic run_entry(input logic [AW-1:0] pc, input logic [AW-1:0] vec,
                           input int b, input int w1, input int w2,
                           input logic h, input logic pulse, input logic noise);
    int p0, v0, l;
    logic [7:0] e;
    p0 = D + b + 1;
    v0 = p0 + w1 + 1;
    l  = v0 + w2 + 1;
    exp_q.push_back(pc);
    exp_q.push_back(vec);
    for (int k = 0; k <= l + 1; k++) begin
      intr_flag = (k == 0) || (!pulse && k <= l);
      hlt       = h;
      rti       = (noise && k == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k >= 1 && k <= D + b) pipe_busy = (k < D + b);
      else pipe_busy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pc_in = (k <= D + b || !noise) ? pc : AW'($urandom_range(0, 255));
      if (k == p0 + w1) bus.push_ack = 1'b1;
      else if (k >= p0 && k < p0 + w1) bus.push_ack = 1'b0;
      else bus.push_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == v0 + w2) bus.vec_ack = 1'b1;
      else if (k >= v0 && k < v0 + w2) bus.vec_ack = 1'b0;
      else bus.vec_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.vec_data = (k == v0 + w2) ? vec : AW'($urandom_range(0, 255));
      #1;
      e = {(k >= 1 && k <= l), (k == 1), (k >= p0 && k <= p0 + w1),
           (k >= v0 && k <= v0 + w2), (k == l), (k == l), (k == l && h), (k > l)};
      chk($sformatf("outs_c%0d", k), outs(), e);
      if (k >= p0 && k < p0 + w1) chk("push_data_hold", bus.push_data, pc);
      if (k == p0 + w1 && exp_q.size() > 0) chk("push_data", bus.push_data, exp_q.pop_front());
      if (k >= v0 && k <= v0 + w2) chk("vec_addr", bus.vec_addr, VADDR);
      if (k == l && exp_q.size() > 0) chk("pc_load_val", bus.pc_load_val, exp_q.pop_front());
      tick();
    end
    bus.push_ack = 1'b0;
    bus.vec_ack  = 1'b0;
  endtask

  // Stay n cycles in SERVICE, retire RTI, end in IDLE.
  task automatic service(input int n, input logic reflag);
    for (int s = 0; s < n; s++) begin
      intr_flag = reflag; rti = 1'b0;
      bus.push_ack = 1'($urandom_range(0, 1));
      bus.vec_ack  = 1'($urandom_range(0, 1));
      #1;
      chk("service_hold", outs(), 8'b0000_0001);
      tick();
    end
    intr_flag = reflag; rti = 1'b1; bus.push_ack = 1'b0; bus.vec_ack = 1'b0;
    #1;
    chk("service_rti", outs(), 8'b0000_0001);
    tick();
    rti = 1'b0;
    if (!reflag) begin
      intr_flag = 1'b0;
      #1;
      chk("idle_after_rti", outs(), 8'b0000_0000);
      tick();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       flag, rti, pa, va, h, busy;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic spare_flag;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_0000};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b1100_0000};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b1000_0000};

    quiet();
    #1 rst = 1'b0;
    #1;
    chk("reset_outs", outs(), 8'b0000_0000);
    chk("reset_state", dbg_state, 3'd0);
    chk("reset_push_data", bus.push_data, 8'h00);
    chk("reset_pc_load_val", bus.pc_load_val, 8'h00);
    tick();
    rst = 1'b1;

    // Spurious inputs in IDLE, then entry into DRAIN.
    for (int i = 0; i < 7; i++) begin
      intr_flag = tbl[i].flag; rti = tbl[i].rti; hlt = tbl[i].h;
      bus.push_ack = tbl[i].pa; bus.vec_ack = tbl[i].va; pipe_busy = tbl[i].busy;
      #1;
      chk($sformatf("table_row%0d", i), outs(), tbl[i].exp);
      tick();
    end

    // Asynchronous reset out of DRAIN.
    quiet();
    #2 rst = 1'b0;
    #1;
    chk("reset_from_drain", outs(), 8'b0000_0000);
    tick();
    rst = 1'b1;
    tick();

    // Basic entry: pc_load at cycle 6.
    run_entry(8'h24, 8'h80, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    service(2, 1'b0);

    // Backpressure: +4 busy, +3 push wait, +2 vector wait -> cycle 15.
    run_entry(8'h24, 8'h80, 4, 3, 2, 1'b0, 1'b0, 1'b0);
    // Flag re-raised during SERVICE: no nesting, then re-entry from IDLE.
    service(3, 1'b1);
    run_entry(8'h55, 8'hA0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    service(0, 1'b0);

    // HLT wake with a single-cycle flag pulse.
    run_entry(8'h10, 8'hC0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    service(1, 1'b0);
    hlt = 1'b0;

    // Reset during PUSH with push_req high.
    quiet();
    intr_flag = 1'b1;
    pc_in = 8'h3C;
    for (int k = 0; k < D + 1; k++) tick();
    chk("push_before_reset", outs(), 8'b1010_0000);
    #2 rst = 1'b0;
    #1;
    chk("reset_mid_push", outs(), 8'b0000_0000);
    chk("reset_mid_push_data", bus.push_data, 8'h00);
    chk("reset_mid_state", dbg_state, 3'd0);
    tick();
    #1;
    chk("reset_held", outs(), 8'b0000_0000);
    tick();
    rst = 1'b1;
    run_entry(8'h3C, 8'h9E, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    service(1, 1'b0);

    // Randomized entries with stray acks, busy noise and moving pc_in.
    spare_flag = 1'b0;
    for (int it = 0; it < 25; it++) begin
      logic [AW-1:0] rpc, rvec;
      rpc  = AW'($urandom_range(0, 255));
      rvec = AW'($urandom_range(0, 255));
      run_entry(rpc, rvec, $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b1);
      spare_flag = 1'($urandom_range(0, 1));
      service($urandom_range(0, 3), spare_flag);
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
